fa_16bits: RTL and testbench

- Registered 16-bit binary adder with carry-in and carry-out.
- Datapath adder for the multi-cycle 16-bit RISC computer; used by the ALU and PC-increment paths.
- Combinational core is a ripple-carry chain of 1-bit full-adder cells.
- Sum and carry are captured in output registers on the rising clock edge.

---
 rtl/fa_16bits_pkg.sv | 9 +
 rtl/fa_16bits_full_adder_1bit.sv | 14 +
 rtl/fa_16bits.sv | 58 +++++
 tb/tb_fa_16bits.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fa_16bits_pkg.sv
// Shared datapath definitions for the 16-bit RISC core.
// Word width and word type used by the adder and its users.
package fa_16bits_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/fa_16bits_full_adder_1bit.sv
// One full-adder cell; chained to form the ripple adder.
// Purely combinational.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_16bits.sv
// Registered ripple-carry adder with carry in/out.
// One-cycle latency, result held while in_valid is low.
module fa_16bits
  import fa_16bits_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             v_d, v_q;

  assign carry[0] = C_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder_1bit u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (s_d[i]),
      .cout (carry[i+1])
    );
  end

  assign c_d = carry[WIDTH];
  assign v_d = in_valid;

  // Sum/carry only load on in_valid; valid flag follows it every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
      if (in_valid) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end
  end

  assign S         = s_q;
  assign C_out     = c_q;
  assign out_valid = v_q;

endmodule

// File: tb/tb_fa_16bits.sv
// Self-checking bench for fa_16bits: directed cases plus
// back-to-back random operands against a 17-bit arithmetic model.
module tb_fa_16bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A, B;
  logic        C_in;
  logic [15:0] S;
  logic        C_out;
  logic        out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] m_res;
  logic        m_v;

  always #5 clk = ~clk;

  fa_16bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .S         (S),
    .C_out     (C_out),
    .out_valid (out_valid)
  );

  task automatic check(input string tag,
                       input logic [16:0] obs,
                       input logic [16:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one edge, advance the model, compare outputs.
  task automatic cycle(input logic r, input logic v,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic c,
                       input string tag);
    rst_n = r; in_valid = v;
    A = a; B = b; C_in = c;
    @(posedge clk);
    #1;
    if (!r) begin
      m_res = '0;
      m_v   = 1'b0;
    end else begin
      m_v = v;
      if (v) m_res = {1'b0, a} + {1'b0, b} + {16'd0, c};
    end
    check({tag, "/res"}, {C_out, S}, m_res);
    check({tag, "/vld"}, {16'd0, out_valid}, {16'd0, m_v});
  endtask

  initial begin
    m_res = '0; m_v = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; C_in = 1'b0;

    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "reset");
    check("reset_const", {C_out, S}, 17'h0);

    cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, "basic");
    check("basic_const", {C_out, S}, 17'h068AC);

    cycle(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, "ripple");
    check("ripple_const", {C_out, S}, 17'h10000);

    cycle(1'b1, 1'b1, 16'h0000, 16'h0005, 1'b1, "cin");
    check("cin_const", {C_out, S}, 17'h00006);

    cycle(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "max");
    check("max_const", {C_out, S}, 17'h1FFFF);

    cycle(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, "hold_a");
    cycle(1'b1, 1'b0, 16'h00FF, 16'h0001, 1'b0, "hold_b");
    check("hold_const", {C_out, S}, 17'h00002);
    check("hold_vld", {16'd0, out_valid}, 17'h0);

    cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, "pre_rst");
    // A reset pulse between edges must not disturb the registers.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("midpulse_res", {C_out, S}, 17'h068AC);
    check("midpulse_vld", {16'd0, out_valid}, 17'h1);

    cycle(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b1, "rst_mid");
    check("rst_mid_const", {C_out, S}, 17'h0);
    cycle(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1, "post_rst");
    check("post_rst_const", {C_out, S}, 17'h10001);

    for (int i = 0; i < 1200; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      cycle(1'b1, 1'b1, ra, rb, rc, "rand");
    end

    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom),
            1'($urandom), "rand_v");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
